// File: rtl/countdown_timer_ndig_pkg.sv
// Shared widths, state encoding and BCD helpers for the N-digit countdown timer.
package countdown_timer_ndig_pkg;

    localparam int BCD_BIT_WIDTH       = 4;
    localparam int TMR_STATE_BIT_WIDTH = 2;
    localparam logic [BCD_BIT_WIDTH-1:0] BCD_NINE = 4'd9;

    typedef enum logic [TMR_STATE_BIT_WIDTH-1:0] {
        TMR_IDLE  = 2'd0,
        TMR_RUN   = 2'd1,
        TMR_PAUSE = 2'd2,
        TMR_DONE  = 2'd3
    } tmr_state_t;

    function automatic logic [BCD_BIT_WIDTH-1:0] bcd_clamp(input logic [BCD_BIT_WIDTH-1:0] v);
        return (v > BCD_NINE) ? BCD_NINE : v;
    endfunction

endpackage

// File: rtl/countdown_timer_ndig_bcd_digit_down.sv
// One BCD down-counting digit with clamped parallel load.
// borrow_out flags a zero digit; the top chains it so a decrement ripples upward.
module bcd_digit_down
    import countdown_timer_ndig_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [BCD_BIT_WIDTH-1:0] load_val,
    input  logic                     dec_in,
    output logic [BCD_BIT_WIDTH-1:0] digit,
    output logic                     borrow_out
);

    assign borrow_out = (digit == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digit <= '0;
        end else if (load) begin
            digit <= bcd_clamp(load_val);
        end else if (dec_in) begin
            digit <= borrow_out ? BCD_NINE : digit - 4'd1;
        end
    end

endmodule

// File: rtl/countdown_timer_ndig.sv
// N-digit BCD countdown timer: tick prescaler, preset load, start/pause control
// and a flashing alarm bus.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// TMR_IDLE  | stopped, prescaler held at 0, waiting for start
// TMR_RUN   | prescaler counting, count decrements on each tick
// TMR_PAUSE | prescaler and count frozen, sub-tick phase preserved
// TMR_DONE  | count reached 0, led toggles on every tick until acknowledged
module countdown_timer_ndig
    import countdown_timer_ndig_pkg::*;
#(
    parameter int NDIG     = 4,
    parameter int TICK_DIV = 100_000_000,
    parameter int LED_W    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_stop,
    input  logic                          load,
    input  logic [BCD_BIT_WIDTH*NDIG-1:0] preset_bcd,
    output logic [BCD_BIT_WIDTH*NDIG-1:0] bcd_out,
    output logic                          running,
    output logic                          expired,
    output logic [LED_W-1:0]              led
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int CW = BCD_BIT_WIDTH * NDIG;

    tmr_state_t      state;
    logic [PW-1:0]   presc;
    logic [PW-1:0]   presc_next;
    logic            tick;
    logic            count_zero;
    logic            count_one;
    logic [NDIG-1:0] dec_chain;
    logic [NDIG-1:0] borrow;

    assign tick       = ((state == TMR_RUN) || (state == TMR_DONE)) && (presc == PW'(TICK_DIV - 1));
    assign presc_next = tick ? '0 : presc + PW'(1);
    assign count_zero = &borrow;
    assign count_one  = (bcd_out == CW'(1));

    // Decrement enable ripples up through every digit that is currently zero.
    assign dec_chain[0] = tick && (state == TMR_RUN);

    genvar k;
    generate
        for (k = 0; k < NDIG; k++) begin : g_digit
            if (k > 0) begin : g_chain
                assign dec_chain[k] = dec_chain[k-1] & borrow[k-1];
            end
            bcd_digit_down u_digit (
                .clk       (clk),
                .rst       (rst),
                .load      (load),
                .load_val  (preset_bcd[k*BCD_BIT_WIDTH +: BCD_BIT_WIDTH]),
                .dec_in    (dec_chain[k]),
                .digit     (bcd_out[k*BCD_BIT_WIDTH +: BCD_BIT_WIDTH]),
                .borrow_out(borrow[k])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= TMR_IDLE;
            presc   <= '0;
            led     <= '0;
            running <= 1'b0;
            expired <= 1'b0;
        end else if (load) begin
            state   <= TMR_IDLE;
            presc   <= '0;
            led     <= '0;
            running <= 1'b0;
            expired <= 1'b0;
        end else begin
            case (state)
                TMR_IDLE: begin
                    presc <= '0;
                    if (start_stop && !count_zero) begin
                        state   <= TMR_RUN;
                        running <= 1'b1;
                    end
                end
                TMR_RUN: begin
                    presc <= presc_next;
                    // Reaching zero takes precedence over a same-cycle pause request.
                    if (tick && count_one) begin
                        state   <= TMR_DONE;
                        running <= 1'b0;
                        expired <= 1'b1;
                        led     <= '1;
                    end else if (start_stop) begin
                        state   <= TMR_PAUSE;
                        running <= 1'b0;
                    end
                end
                TMR_PAUSE: begin
                    if (start_stop) begin
                        state   <= TMR_RUN;
                        running <= 1'b1;
                    end
                end
                TMR_DONE: begin
                    if (start_stop) begin
                        state   <= TMR_IDLE;
                        expired <= 1'b0;
                        led     <= '0;
                        presc   <= '0;
                    end else begin
                        presc <= presc_next;
                        if (tick) begin
                            led <= ~led;
                        end
                    end
                end
                default: begin
                    state <= TMR_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_countdown_timer_ndig.sv
// Directed bench for countdown_timer_ndig with a decimal-arithmetic reference model
// compared on every falling clock edge, plus hand-computed checkpoints.
module tb_countdown_timer_ndig;

    localparam int NDIG     = 4;
    localparam int TICK_DIV = 4;
    localparam int LED_W    = 16;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start_stop = 1'b0;
    logic              load = 1'b0;
    logic [4*NDIG-1:0] preset_bcd = '0;
    logic [4*NDIG-1:0] bcd_out;
    logic              running;
    logic              expired;
    logic [LED_W-1:0]  led;

    int n_checks = 0;
    int n_fail   = 0;

    int m_count = 0;
    int m_phase = 0;
    int m_mode  = M_IDLE;
    bit m_led   = 1'b0;

    countdown_timer_ndig #(
        .NDIG    (NDIG),
        .TICK_DIV(TICK_DIV),
        .LED_W   (LED_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_stop(start_stop),
        .load      (load),
        .preset_bcd(preset_bcd),
        .bcd_out   (bcd_out),
        .running   (running),
        .expired   (expired),
        .led       (led)
    );

    always #5 clk = ~clk;

    function automatic int clamp_dec(input logic [4*NDIG-1:0] p);
        int v = 0;
        int mul = 1;
        for (int k = 0; k < NDIG; k++) begin
            int d = int'(p[4*k +: 4]);
            if (d > 9) d = 9;
            v += d * mul;
            mul *= 10;
        end
        return v;
    endfunction

    function automatic logic [4*NDIG-1:0] to_bcd(input int v);
        logic [4*NDIG-1:0] r = '0;
        int x = v;
        for (int k = 0; k < NDIG; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the count is a plain integer and the prescaler phase is
    // the number of RUN/DONE cycles since the last tick.
    always @(posedge clk or negedge rst) begin : model
        int c, p, md;
        bit l;
        if (!rst) begin
            m_count <= 0;
            m_phase <= 0;
            m_mode  <= M_IDLE;
            m_led   <= 1'b0;
        end else begin
            c = m_count; p = m_phase; md = m_mode; l = m_led;
            if (load) begin
                c = clamp_dec(preset_bcd); p = 0; md = M_IDLE; l = 1'b0;
            end else begin
                case (md)
                    M_IDLE: begin
                        p = 0;
                        if (start_stop && c != 0) md = M_RUN;
                    end
                    M_RUN: begin
                        p++;
                        if (p == TICK_DIV) begin
                            p = 0;
                            c--;
                            if (c == 0) begin
                                md = M_DONE;
                                l  = 1'b1;
                            end
                        end
                        if (md == M_RUN && start_stop) md = M_PAUSE;
                    end
                    M_PAUSE: begin
                        if (start_stop) md = M_RUN;
                    end
                    default: begin
                        p++;
                        if (p == TICK_DIV) begin
                            p = 0;
                            l = ~l;
                        end
                        if (start_stop) begin
                            md = M_IDLE; l = 1'b0; p = 0;
                        end
                    end
                endcase
            end
            m_count <= c; m_phase <= p; m_mode <= md; m_led <= l;
        end
    end

    always @(negedge clk) begin
        check("cyc.bcd_out", 32'(bcd_out), 32'(to_bcd(m_count)));
        check("cyc.running", 32'(running), 32'(m_mode == M_RUN));
        check("cyc.expired", 32'(expired), 32'(m_mode == M_DONE));
        check("cyc.led", 32'(led), m_led ? 32'hFFFF : 32'h0);
    end

    task automatic expect_out(input string name, input logic [15:0] b, input logic r,
                              input logic e, input logic [15:0] l);
        check({name, ".bcd"}, 32'(bcd_out), 32'(b));
        check({name, ".running"}, 32'(running), 32'(r));
        check({name, ".expired"}, 32'(expired), 32'(e));
        check({name, ".led"}, 32'(led), 32'(l));
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v);
        preset_bcd = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic pulse_ss();
        start_stop = 1'b1;
        @(negedge clk);
        start_stop = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        wait_cycles(2);
        expect_out("reset", 16'h0000, 1'b0, 1'b0, 16'h0000);
        rst = 1'b1;
        @(negedge clk);

        // 1: async reset mid-run
        do_load(16'h0042);
        pulse_ss();
        wait_cycles(2);
        expect_out("t1.pre", 16'h0042, 1'b1, 1'b0, 16'h0000);
        #2 rst = 1'b0;
        #1 expect_out("t1.rst_now", 16'h0000, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        wait_cycles(20);
        expect_out("t1.idle", 16'h0000, 1'b0, 1'b0, 16'h0000);

        // 2: decrement with two-digit borrow
        do_load(16'h0102);
        expect_out("t2.load", 16'h0102, 1'b0, 1'b0, 16'h0000);
        pulse_ss();
        expect_out("t2.start", 16'h0102, 1'b1, 1'b0, 16'h0000);
        wait_cycles(3);
        expect_out("t2.c3", 16'h0102, 1'b1, 1'b0, 16'h0000);
        wait_cycles(1);
        expect_out("t2.c4", 16'h0101, 1'b1, 1'b0, 16'h0000);
        wait_cycles(4);
        expect_out("t2.c8", 16'h0100, 1'b1, 1'b0, 16'h0000);
        wait_cycles(4);
        expect_out("t2.c12", 16'h0099, 1'b1, 1'b0, 16'h0000);

        // 3: pause preserves sub-tick phase
        do_load(16'h0002);
        pulse_ss();
        wait_cycles(1);
        pulse_ss();
        wait_cycles(10);
        expect_out("t3.paused", 16'h0002, 1'b0, 1'b0, 16'h0000);
        pulse_ss();
        wait_cycles(1);
        expect_out("t3.res1", 16'h0002, 1'b1, 1'b0, 16'h0000);
        wait_cycles(1);
        expect_out("t3.res2", 16'h0001, 1'b1, 1'b0, 16'h0000);

        // 4: expiry, flashing, acknowledge
        do_load(16'h0001);
        pulse_ss();
        wait_cycles(3);
        expect_out("t4.c3", 16'h0001, 1'b1, 1'b0, 16'h0000);
        wait_cycles(1);
        expect_out("t4.done", 16'h0000, 1'b0, 1'b1, 16'hFFFF);
        wait_cycles(4);
        expect_out("t4.flash", 16'h0000, 1'b0, 1'b1, 16'h0000);
        wait_cycles(4);
        expect_out("t4.flash2", 16'h0000, 1'b0, 1'b1, 16'hFFFF);
        pulse_ss();
        expect_out("t4.ack", 16'h0000, 1'b0, 1'b0, 16'h0000);
        pulse_ss();
        expect_out("t4.zero_start", 16'h0000, 1'b0, 1'b0, 16'h0000);

        // 5: clamp and load-beats-start_stop
        do_load(16'h0005);
        pulse_ss();
        expect_out("t5.run", 16'h0005, 1'b1, 1'b0, 16'h0000);
        preset_bcd = 16'hF9A3;
        load = 1'b1;
        start_stop = 1'b1;
        @(negedge clk);
        expect_out("t5.load_ss_run", 16'h9993, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        load = 1'b0;
        start_stop = 1'b0;
        expect_out("t5.load_ss_idle", 16'h9993, 1'b0, 1'b0, 16'h0000);
        pulse_ss();
        expect_out("t5.start", 16'h9993, 1'b1, 1'b0, 16'h0000);

        // 6: full borrow chain, then load during RUN resets the prescaler
        do_load(16'h1000);
        pulse_ss();
        wait_cycles(3);
        expect_out("t6.c3", 16'h1000, 1'b1, 1'b0, 16'h0000);
        wait_cycles(1);
        expect_out("t6.c4", 16'h0999, 1'b1, 1'b0, 16'h0000);
        wait_cycles(2);
        do_load(16'h0003);
        expect_out("t6.reload", 16'h0003, 1'b0, 1'b0, 16'h0000);
        pulse_ss();
        wait_cycles(3);
        expect_out("t6.r3", 16'h0003, 1'b1, 1'b0, 16'h0000);
        wait_cycles(1);
        expect_out("t6.r4", 16'h0002, 1'b1, 1'b0, 16'h0000);

        wait_cycles(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/countdown_timer_ndig.md
# countdown_timer_ndig

Parametrised N-digit BCD countdown timer core. It replaces the fixed two-digit down counter and external enable FSM with a single block that contains:
- an internal 1 Hz tick prescaler,
- a preset load,
- a start/pause/resume control FSM,
- a flashing alarm output.

The block sits between the debounced push-button logic and the scan control / 7-segment display path. The `bcd_out` digits feed `scan_ctl` directly.

## Interface
Parameters:
- `NDIG`, 4, number of BCD digits (1–8)
- `TICK_DIV`, 100_000_000, clk cycles per count tick (≥2)
- `LED_W`, 16, alarm LED bus width

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-low
- `start_stop`  in  1  one-cycle pulse (pre-debounced): start / pause / resume / acknowledge
- `load`  in  1  one-cycle pulse: load `preset_bcd` and go idle
- `preset_bcd`  in  4*NDIG  preset value, digit 0 in bits [3:0]
- `bcd_out`  out  4*NDIG  current count, digit 0 in bits [3:0]
- `running`  out  1  high in RUN
- `expired`  out  1  high in DONE
- `led`  out  LED_W  alarm flash bus

## Operation
- Reset values: state IDLE, all digits 0, prescaler 0, `running`=0, `expired`=0, `led`=0.
- FSM states and transitions:
  - IDLE –start_stop & count≠0→ RUN.
  - IDLE –start_stop & count=0→ stays IDLE.
  - RUN –start_stop→ PAUSE.
  - PAUSE –start_stop→ RUN.
  - RUN –tick & count=1→ DONE. The count becomes 0 on the same edge.
  - DONE –start_stop→ IDLE. The count stays 0.
- `load` in any state:
  - next state IDLE,
  - digits ← `preset_bcd` with any digit >9 clamped to 9,
  - prescaler ← 0,
  - `led` ← 0.
- Simultaneous `load` and `start_stop`: `load` wins and `start_stop` is ignored.
- Prescaler behaviour by state:
  - RUN and DONE: counts 0..TICK_DIV-1 and wraps. Tick = one-cycle internal strobe at value TICK_DIV-1.
  - PAUSE: holds its value, so resume continues the partial second.
  - IDLE: held at 0.
  - The IDLE→RUN transition starts the prescaler from 0.
- Decrement on each tick in RUN:
  - Digit 0 decrements.
  - A digit at 0 becomes 9 and borrows from the next digit.
  - The borrow chain is combinational across all NDIG digits and is registered once.
  - The count never wraps below 0, because DONE is entered at 0.
- DONE:
  - `led` toggles between all-ones and all-zeros on every tick.
  - The first toggle sets all-ones on the same edge that enters DONE.
  - Leaving DONE forces `led` to 0.
- `running` = (state==RUN) and `expired` = (state==DONE). Both are registered and updated on the edge that changes the state.

## Timing
- Outputs update only on the rising `clk` edge. The exception is `rst` low, which forces reset values immediately.
- `start_stop` sampled high at edge n → `running` changes at edge n.
- First decrement after IDLE→RUN occurs TICK_DIV cycles after the start edge.
- `load` sampled at edge n → `bcd_out`=clamped preset after edge n. There is no extra latency.
- Pause/resume preserves sub-second phase: total RUN cycles per decrement is always TICK_DIV.
- `rst` asserted mid-count: everything returns to reset values and the preset is not reloaded.

## Structure
- Add to global.v:
  - `` `BCD_BIT_WIDTH`` (existing)
  - `` `TMR_STATE_BIT_WIDTH`` = 2
  - `` `TMR_IDLE``=0, `` `TMR_RUN``=1, `` `TMR_PAUSE``=2, `` `TMR_DONE``=3
  - `` `BCD_NINE``=4'd9
- Sub-module `bcd_digit_down`: one digit with inputs `dec_in` and `load_val`, outputs `digit` and `borrow_out`, plus clamp logic.
  - Instantiated NDIG times in a generate loop.
  - `dec_in` of digit k = tick & borrow of digit k-1.
- Prescaler, FSM and LED flash stay in the top module.

## Test plan
All scenarios use TICK_DIV=4, NDIG=4 and LED_W=16.
1. Reset low mid-run with count 0042 → `bcd_out`=0000, `running`=0, `expired`=0 and `led`=0 immediately; release, no activity for 20 cycles → count stays 0000.
2. Load 0102, start, run 12 cycles → after 4 cycles 0101, then 0100, then 0099 (borrow across two digits). `running`=1 throughout.
3. Load 0002, start, 2 cycles, pause for 10 cycles, resume → decrement occurs 2 RUN cycles after resume, giving 0001. The count does not change while paused.
4. Load 0001, start → after 4 cycles `bcd_out`=0000, `expired`=1, `led`=FFFF; 4 cycles later `led`=0000; `start_stop` → IDLE, `led`=0000. A further `start_stop` in IDLE with count 0 stays IDLE.
5. `preset_bcd`=16'hF9A3 → loaded value 9993. Load and start_stop in the same cycle → IDLE, count 9993, `running`=0.
6. Load 1000, start, 4 cycles → 0999 (full borrow chain). Load during RUN → IDLE with the new preset and prescaler 0.
